addsub_issue: RTL and testbench
===============================

# addsub_issue

Issue-side controller for the two-lane add/sub execution unit. Accepts one ALU add/sub request at a time over a valid/ready handshake and selects an adder lane round-robin. Drives the unit's start/use_part/op_mode protocol, waits for done, captures res, and presents the result on a valid/ready writeback port. A watchdog bounds the wait and turns a missing done into an error writeback.

## Interface
- TIMEOUT, 16: maximum WAIT cycles before the watchdog fires; range 2..255.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept; high only in IDLE.
- in_op1 / in_op2  in  32  operands.
- in_mode1  in  2  forwarded op_mode1.
- in_mode2  in  3  forwarded op_mode2; bit 2 = 1 selects subtract.
- in_rd  in  5  destination tag, returned with the result.
- as_op1 / as_op2  out  32  operands to the unit.
- as_start  out  1  one-cycle start pulse.
- as_use_part  out  2  lane select: 01 = lane 0, 10 = lane 1, 00 = idle.
- as_op_mode1  out  2  to the unit.
- as_op_mode2  out  3  to the unit.
- as_done  in  1  unit completion.
- as_res  in  32  unit result; valid in the cycle as_done is high.
- wb_valid  out  1  result available.
- wb_ready  in  1  consumer accepts.
- wb_rd  out  5  tag of the result.
- wb_data  out  32  result.
- wb_err  out  1  result produced by watchdog.
- done_cnt  out  16  count of good writebacks; wraps.
- err_cnt  out  8  count of error writebacks; saturates at 8'hFF.

## Operation
- FSM: IDLE -> ISSUE -> WAIT -> WB -> IDLE.
- IDLE: in_ready = 1. On in_valid, latch op1, op2, mode1, mode2, rd into holding registers and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - as_start = 1.
  - as_use_part = current lane.
  - Go to WAIT.
- WAIT:
  - as_start = 0; as_use_part held at the same lane. The unit drops its lane enable when use_part changes.
  - On as_done = 1: capture as_res into wb_data, set wb_err = 0, go to WB.
  - Otherwise increment the watchdog. When the watchdog equals TIMEOUT-1 and as_done = 0: set wb_data = 0 and wb_err = 1, go to WB.
- WB: wb_valid = 1 and as_use_part = 00. On wb_valid & wb_ready:
  - Toggle the lane.
  - Increment done_cnt (wb_err = 0) or err_cnt (wb_err = 1).
  - Go to IDLE.
- as_op1, as_op2, as_op_mode1, as_op_mode2 come from the holding registers. They are stable from ISSUE through WAIT and are only changed by a new accept.
- as_done is ignored in IDLE, ISSUE and WB. Stale done pulses are discarded.
- Lane register resets to 01 and alternates 01/10 after every writeback, including errors.
- The watchdog clears on entry to WAIT and is held at 0 outside WAIT.
- done_cnt wraps 16'hFFFF -> 0. err_cnt saturates at 8'hFF.

## Timing
- Reset values:
  - State = IDLE; in_ready = 1 in the first cycle after reset.
  - as_start = 0, as_use_part = 00, as_op1/op2 = 0, as_op_mode1/2 = 0.
  - wb_valid = 0, wb_rd = 0, wb_data = 0, wb_err = 0.
  - done_cnt = 0, err_cnt = 0, lane = 01.
- Handshake: accept at edge T. ISSUE is cycle T+1 (as_start high). WAIT starts T+2.
- If as_done is sampled high at cycle D, then wb_valid = 1 in D+1, with wb_data = as_res from cycle D.
- wb_valid stays high and wb_rd/wb_data/wb_err stay stable until wb_ready. After the transfer edge, in_ready = 1 in the next cycle.
- Minimum issue-to-issue spacing: 4 cycles plus unit latency.
- Simultaneous as_done and watchdog expiry in the same cycle: done wins, wb_err = 0.
- wb_ready held permanently high: the transfer happens in the first WB cycle.
- Reset mid-operation (any state): the in-flight request is discarded with no writeback. as_use_part = 00 from the next cycle and the counters clear.

## Test plan
- Add on lane 0: accept op1 = 32'd5, op2 = 32'd7, mode2 = 3'b000, rd = 3. Unit returns done with res = 32'd12. Expect wb_valid, wb_rd = 3, wb_data = 12, wb_err = 0, done_cnt = 1, and as_use_part = 01 during ISSUE and WAIT.
- Sub on lane 1: the second request, op1 = 32'd3, op2 = 32'd5, mode2 = 3'b100, uses as_use_part = 10. res = 32'hFFFF_FFFE is returned on wb_data. A third request returns to lane 01.
- Writeback backpressure: wb_ready low for 5 cycles. Expect wb_valid high and wb_data stable, in_ready low throughout, and one transfer when wb_ready rises.
- Watchdog: TIMEOUT = 4 and as_done never asserts. Expect wb_valid with wb_err = 1, wb_data = 0, err_cnt = 1, and the lane still toggling.
- Stale and coincident done: an as_done pulse in IDLE and in ISSUE is ignored. A done landing on the watchdog's final cycle yields wb_err = 0 with the captured res.
- Reset in WAIT: assert rst for 1 cycle. Expect no writeback, as_use_part = 00, counters = 0, in_ready = 1 after release, and a following request served on lane 01.

Source files
------------

// File: rtl/addsub_issue.sv
// addsub_issue: issue-side controller for the two-lane add/sub execution unit.
// Takes one request at a time, issues it to a round-robin lane, waits for done
// under a watchdog, and returns the result (or an error) on the writeback port.
module addsub_issue #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    // request port
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_op1,
    input  logic [31:0] in_op2,
    input  logic [1:0]  in_mode1,
    input  logic [2:0]  in_mode2,
    input  logic [4:0]  in_rd,
    // execution unit
    output logic [31:0] as_op1,
    output logic [31:0] as_op2,
    output logic        as_start,
    output logic [1:0]  as_use_part,
    output logic [1:0]  as_op_mode1,
    output logic [2:0]  as_op_mode2,
    input  logic        as_done,
    input  logic [31:0] as_res,
    // writeback port
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_err,
    // statistics
    output logic [15:0] done_cnt,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    // Watchdog value on the last permitted WAIT cycle.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  wdog;
    logic        wd_fire;
    logic [1:0]  lane;
    logic [31:0] hold_op1, hold_op2;
    logic [1:0]  hold_mode1;
    logic [2:0]  hold_mode2;
    logic [4:0]  hold_rd;
    logic [31:0] res_q;
    logic        err_q;
    logic        accept, wb_xfer;

    assign accept  = (state == S_IDLE) && in_valid;
    assign wb_xfer = (state == S_WB) && wb_ready;
    assign wd_fire = (wdog == WD_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; done takes priority over watchdog expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (as_done || wd_fire) state_nxt = S_WB;
            S_WB:    if (wb_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Holding registers: only a new accept changes what the unit sees.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_op1   <= '0;
            hold_op2   <= '0;
            hold_mode1 <= '0;
            hold_mode2 <= '0;
            hold_rd    <= '0;
        end else if (accept) begin
            hold_op1   <= in_op1;
            hold_op2   <= in_op2;
            hold_mode1 <= in_mode1;
            hold_mode2 <= in_mode2;
            hold_rd    <= in_rd;
        end
    end

    // Watchdog: counts WAIT cycles, zero everywhere else so each WAIT starts fresh.
    always_ff @(posedge clk) begin
        if (rst)                                          wdog <= '0;
        else if (state == S_WAIT && !as_done && !wd_fire) wdog <= wdog + 8'd1;
        else                                              wdog <= '0;
    end

    // Result capture in WAIT only; done outside WAIT is stale and dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            err_q <= 1'b0;
        end else if (state == S_WAIT) begin
            if (as_done) begin
                res_q <= as_res;
                err_q <= 1'b0;
            end else if (wd_fire) begin
                res_q <= '0;
                err_q <= 1'b1;
            end
        end
    end

    // Lane rotation and statistics, advanced on every writeback transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane     <= 2'b01;
            done_cnt <= '0;
            err_cnt  <= '0;
        end else if (wb_xfer) begin
            lane <= {lane[0], lane[1]};
            if (err_q) begin
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else begin
                done_cnt <= done_cnt + 16'd1;
            end
        end
    end

    assign in_ready    = (state == S_IDLE);
    assign as_start    = (state == S_ISSUE);
    assign as_use_part = (state == S_ISSUE || state == S_WAIT) ? lane : 2'b00;
    assign as_op1      = hold_op1;
    assign as_op2      = hold_op2;
    assign as_op_mode1 = hold_mode1;
    assign as_op_mode2 = hold_mode2;
    assign wb_valid    = (state == S_WB);
    assign wb_rd       = hold_rd;
    assign wb_data     = res_q;
    assign wb_err      = err_q;

endmodule

// File: tb/tb_addsub_issue.sv
// tb_addsub_issue: directed vector bench for addsub_issue (TIMEOUT = 4).
`timescale 1ns/1ps
module tb_addsub_issue;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_op1, in_op2;
    logic [1:0]  in_mode1;
    logic [2:0]  in_mode2;
    logic [4:0]  in_rd;
    logic [31:0] as_op1, as_op2;
    logic        as_start;
    logic [1:0]  as_use_part, as_op_mode1;
    logic [2:0]  as_op_mode2;
    logic        as_done;
    logic [31:0] as_res;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_err;
    logic [15:0] done_cnt;
    logic [7:0]  err_cnt;

    addsub_issue #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op1(in_op1), .in_op2(in_op2), .in_mode1(in_mode1), .in_mode2(in_mode2), .in_rd(in_rd),
        .as_op1(as_op1), .as_op2(as_op2), .as_start(as_start), .as_use_part(as_use_part),
        .as_op_mode1(as_op_mode1), .as_op_mode2(as_op_mode2),
        .as_done(as_done), .as_res(as_res),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err),
        .done_cnt(done_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op1, op2;
        logic [1:0]  m1;
        logic [2:0]  m2;
        logic [4:0]  rd;
        int          lat;    // WAIT cycle index where done is driven; >= TO means never
        logic [31:0] res;
        int          bp;     // cycles of wb_ready low in WB
        bit          stale;  // drive done in IDLE and ISSUE first
    } vec_t;

    vec_t v[6];
    int n_tests = 0, n_fail = 0;
    logic [1:0]  exp_lane;
    logic [15:0] exp_done;
    logic [7:0]  exp_errc;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t t);
        bit err;
        int n;
        err = (t.lat >= TO);
        n = 0;
        while (!in_ready && n < 20) begin step(); n++; end
        chk("idle_ready", 32'(in_ready), 32'd1);
        wb_ready = (t.bp == 0);
        if (t.stale) begin
            as_done = 1'b1; as_res = 32'hBAD0_BAD0;
            step();
            as_done = 1'b0;
            chk("stale_idle_nowb", 32'(wb_valid), 32'd0);
            chk("stale_idle_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b1; in_op1 = t.op1; in_op2 = t.op2;
        in_mode1 = t.m1; in_mode2 = t.m2; in_rd = t.rd;
        step();
        in_valid = 1'b0; in_op1 = '1; in_op2 = '1; in_mode1 = '0; in_mode2 = '0; in_rd = '0;
        // ISSUE cycle
        chk("issue_start", 32'(as_start), 32'd1);
        chk("issue_lane", 32'(as_use_part), 32'(exp_lane));
        chk("issue_ready", 32'(in_ready), 32'd0);
        chk("issue_op1", as_op1, t.op1);
        chk("issue_op2", as_op2, t.op2);
        chk("issue_mode", {27'd0, as_op_mode1, as_op_mode2}, {27'd0, t.m1, t.m2});
        if (t.stale) begin as_done = 1'b1; as_res = 32'hBAD0_BAD0; end
        step();
        as_done = 1'b0;
        for (int i = 0; i < TO; i++) begin
            chk("wait_nowb", 32'(wb_valid), 32'd0);
            chk("wait_lane", 32'(as_use_part), 32'(exp_lane));
            chk("wait_start", 32'(as_start), 32'd0);
            chk("wait_op1", as_op1, t.op1);
            if (i == t.lat) begin as_done = 1'b1; as_res = t.res; end
            step();
            as_done = 1'b0; as_res = 32'h5555_AAAA;
            if (wb_valid) break;
        end
        chk("wb_valid", 32'(wb_valid), 32'd1);
        chk("wb_data", wb_data, err ? 32'd0 : t.res);
        chk("wb_err", 32'(wb_err), 32'(err));
        chk("wb_rd", 32'(wb_rd), 32'(t.rd));
        chk("wb_lane_idle", 32'(as_use_part), 32'd0);
        chk("wb_ready_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < t.bp; i++) begin
            step();
            chk("bp_valid", 32'(wb_valid), 32'd1);
            chk("bp_data", wb_data, err ? 32'd0 : t.res);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        if (err) begin if (exp_errc != 8'hFF) exp_errc++; end
        else exp_done++;
        exp_lane = {exp_lane[0], exp_lane[1]};
        chk("post_wb_valid", 32'(wb_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("done_cnt", 32'(done_cnt), 32'(exp_done));
        chk("err_cnt", 32'(err_cnt), 32'(exp_errc));
    endtask

    initial begin
        //        op1           op2          m1     m2      rd   lat res            bp stale
        v[0] = '{32'd5,        32'd7,       2'd0, 3'b000, 5'd3, 2, 32'd12,        0, 1'b0};
        v[1] = '{32'd3,        32'd5,       2'd1, 3'b100, 5'd4, 0, 32'hFFFF_FFFE, 0, 1'b0};
        v[2] = '{32'h1000_0000, 32'hCEAD_BEEF, 2'd2, 3'b001, 5'd7, 1, 32'hDEAD_BEEF, 5, 1'b0};
        v[3] = '{32'd1,        32'd2,       2'd3, 3'b010, 5'd9, 9, 32'd3,         0, 1'b0};
        v[4] = '{32'h0000_1000, 32'h0000_0234, 2'd0, 3'b000, 5'd17, TO-1, 32'h0000_1234, 0, 1'b1};
        v[5] = '{32'd100,      32'd1,       2'd1, 3'b100, 5'd31, 0, 32'd99,        2, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_op1 = '0; in_op2 = '0; in_mode1 = '0; in_mode2 = '0;
        in_rd = '0; as_done = 1'b0; as_res = '0; wb_ready = 1'b0;
        exp_lane = 2'b01; exp_done = '0; exp_errc = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_start", 32'(as_start), 32'd0);
        chk("rst_use_part", 32'(as_use_part), 32'd0);
        chk("rst_ops", as_op1 | as_op2, 32'd0);
        chk("rst_modes", {27'd0, as_op_mode1, as_op_mode2}, 32'd0);
        chk("rst_wb", {25'd0, wb_valid, wb_rd, wb_err}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_cnts", {8'd0, done_cnt, err_cnt}, 32'd0);

        for (int k = 0; k < 6; k++) run_txn(v[k]);

        // Reset during WAIT: request discarded, counters and lane cleared.
        in_valid = 1'b1; in_op1 = 32'd8; in_op2 = 32'd9; in_mode1 = 2'd1; in_mode2 = 3'b011; in_rd = 5'd12;
        step();
        in_valid = 1'b0;
        step(); step();
        chk("rstw_in_wait", 32'(as_use_part), 32'(exp_lane));
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_lane = 2'b01; exp_done = '0; exp_errc = '0;
        chk("rstw_use_part", 32'(as_use_part), 32'd0);
        chk("rstw_in_ready", 32'(in_ready), 32'd1);
        chk("rstw_cnts", {8'd0, done_cnt, err_cnt}, 32'd0);
        as_done = 1'b1; as_res = 32'hFACE_FACE;
        step();
        as_done = 1'b0;
        chk("rstw_no_wb", 32'(wb_valid), 32'd0);
        step();
        chk("rstw_no_wb2", 32'(wb_valid), 32'd0);
        run_txn(v[0]);
        run_txn(v[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got hang expected finish");
        $fatal(1, "time limit");
    end

endmodule
